muldiv_unit: RTL and testbench

Iterative multiply/divide unit owning the HI/LO register pair, parametrised in datapath width. It is the multi-cycle successor to single-cycle HI/LO arithmetic inside the execute stage. The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start/busy handshake. The pipeline stalls MFHI/MFLO and any new mul/div while busy is high.

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit owning the HI/LO pair
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               is_div_q;
    logic               neg_q;
    logic               neg_rem_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               op_is_div;
    logic               op_signed;
    logic               sign_rs;
    logic               sign_rt;
    logic [WIDTH-1:0]   mag_rs;
    logic [WIDTH-1:0]   mag_rt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               zero_div;

    assign op_is_div = op[1];
    assign op_signed = ~op[0];

    // A zero divisor takes the raw unsigned path so HI ends up holding rs untouched.
    assign sign_rs = op_signed & rs[WIDTH-1] & ~(op_is_div & (rt == '0));
    assign sign_rt = op_signed & rt[WIDTH-1];
    assign mag_rs  = sign_rs ? -rs : rs;
    assign mag_rt  = sign_rt ? -rt : rt;

    // Multiply: acc = {partial product, remaining multiplier bits}, b_q = multiplicand.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

    // Divide: acc = {partial remainder, dividend/quotient bits}, b_q = divisor.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, b_q};

    assign acc_d = is_div_q
        ? {(div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0]),
           acc_q[WIDTH-2:0], ~div_diff[WIDTH]}
        : {mul_sum, acc_q[WIDTH-1:1]};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign zero_div = is_div_q & (b_q == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !cancel) begin
                        if (!op[2]) begin
                            state_q   <= RUN;
                            busy_q    <= 1'b1;
                            dbz_q     <= 1'b0;
                            cnt_q     <= '0;
                            is_div_q  <= op_is_div;
                            b_q       <= op_is_div ? mag_rt : mag_rs;
                            acc_q     <= {{WIDTH{1'b0}}, (op_is_div ? mag_rs : mag_rt)};
                            neg_q     <= sign_rs ^ sign_rt;
                            neg_rem_q <= sign_rs;
                        end else if (op == 3'd4) begin
                            hi_q <= rs;
                        end else if (op == 3'd5) begin
                            lo_q <= rs;
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!cancel) begin
                        done_q <= 1'b1;
                        dbz_q  <= zero_div;
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=16
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start_a, start_b, cancel_a, cancel_b;
    logic [2:0]  op_r;
    logic [31:0] rs_r, rt_r;
    logic        busy_a, done_a, dbz_a;
    logic [31:0] hi_a, lo_a;
    logic        busy_b, done_b, dbz_b;
    logic [15:0] hi_b, lo_b;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(32)) dut_a (
        .CLK(CLK), .RST(RST), .start(start_a), .op(op_r), .rs(rs_r), .rt(rt_r),
        .cancel(cancel_a), .busy(busy_a), .done(done_a), .div_by_zero(dbz_a),
        .hi(hi_a), .lo(lo_a)
    );

    muldiv_unit #(.WIDTH(16)) dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .op(op_r), .rs(rs_r[15:0]), .rt(rt_r[15:0]),
        .cancel(cancel_b), .busy(busy_b), .done(done_b), .div_by_zero(dbz_b),
        .hi(hi_b), .lo(lo_b)
    );

    function automatic logic        busy_of(input int w); return (w == 32) ? busy_a : busy_b; endfunction
    function automatic logic        done_of(input int w); return (w == 32) ? done_a : done_b; endfunction
    function automatic logic        dbz_of (input int w); return (w == 32) ? dbz_a  : dbz_b;  endfunction
    function automatic logic [31:0] hi_of  (input int w); return (w == 32) ? hi_a : {16'h0, hi_b}; endfunction
    function automatic logic [31:0] lo_of  (input int w); return (w == 32) ? lo_a : {16'h0, lo_b}; endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 32) start_a = v; else start_b = v;
    endtask

    task automatic set_cancel(input int w, input logic v);
        if (w == 32) cancel_a = v; else cancel_b = v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [2:0] o,
                                   input logic [31:0] a_in, input logic [31:0] b_in);
        exp_t        e;
        logic [31:0] m, a, b;
        longint      sa, sb_v, ua, ub, q, r;
        logic [63:0] p;
        m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a  = a_in & m;
        b  = b_in & m;
        sa   = (w == 32) ? longint'($signed(a)) : longint'($signed(a[15:0]));
        sb_v = (w == 32) ? longint'($signed(b)) : longint'($signed(b[15:0]));
        ua = longint'(a);
        ub = longint'(b);
        e  = '0;
        if (o < 3'd2) begin
            p = (o == 3'd0) ? 64'(sa * sb_v) : 64'(ua * ub);
            if (w == 32) begin
                e.hi = p[63:32];
                e.lo = p[31:0];
            end else begin
                e.hi = {16'h0, p[31:16]};
                e.lo = {16'h0, p[15:0]};
            end
        end else if (b == 32'h0) begin
            e.lo  = m;
            e.hi  = a;
            e.dbz = 1'b1;
        end else begin
            if (o == 3'd2) begin
                q = sa / sb_v;
                r = sa % sb_v;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            e.lo = q[31:0] & m;
            e.hi = r[31:0] & m;
        end
        return e;
    endfunction

    task automatic issue(input int w, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int cancel_at, input bit poke);
        int          n;
        logic [31:0] pre_hi, pre_lo;
        exp_t        e;
        pre_hi = hi_of(w);
        pre_lo = lo_of(w);
        op_r = o; rs_r = a; rt_r = b;
        set_start(w, 1'b1);
        @(posedge CLK); #1;
        set_start(w, 1'b0);
        sb.push_back(model(w, o, a, b));
        check("accept_busy", 64'(busy_of(w)), 64'd1);
        check("accept_dbz_clear", 64'(dbz_of(w)), 64'd0);
        n = 0;
        while (busy_of(w) && n < 2 * w + 8) begin
            n++;
            if (poke && n == 3) begin
                op_r = 3'd1; rs_r = 32'h3; rt_r = 32'h3;
                set_start(w, 1'b1);
            end
            if (n == cancel_at) set_cancel(w, 1'b1);
            @(posedge CLK); #1;
            set_start(w, 1'b0);
            set_cancel(w, 1'b0);
        end
        e = sb.pop_front();
        if (cancel_at > 0) begin
            check("cancel_len", 64'(n), 64'(cancel_at));
            check("cancel_no_done", 64'(done_of(w)), 64'd0);
            check("cancel_hi_kept", 64'(hi_of(w)), 64'(pre_hi));
            check("cancel_lo_kept", 64'(lo_of(w)), 64'(pre_lo));
        end else begin
            check("busy_len", 64'(n), 64'(w + 1));
            check("done", 64'(done_of(w)), 64'd1);
            check("hi", 64'(hi_of(w)), 64'(e.hi));
            check("lo", 64'(lo_of(w)), 64'(e.lo));
            check("dbz", 64'(dbz_of(w)), 64'(e.dbz));
            @(posedge CLK); #1;
            check("done_one_cycle", 64'(done_of(w)), 64'd0);
        end
    endtask

    task automatic run_suite(input int w);
        logic [31:0] mneg;
        mneg = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
        issue(w, 3'd0, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
        issue(w, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        issue(w, 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        issue(w, 3'd2, mneg, 32'hFFFF_FFFF, 0, 1'b0);
        issue(w, 3'd3, 32'd5, 32'd0, 0, 1'b0);
        issue(w, 3'd0, 32'd1234, 32'hFFFF_FFD9, 0, 1'b0);
        issue(w, 3'd2, 32'hFFFF_FC18, 32'd33, 0, 1'b1);

        op_r = 3'd4; rs_r = 32'h1234;
        set_start(w, 1'b1);
        @(posedge CLK); #1;
        check("mthi_no_busy", 64'(busy_of(w)), 64'd0);
        op_r = 3'd5; rs_r = 32'h5678;
        @(posedge CLK); #1;
        op_r = 3'd6; rs_r = 32'hFFFF;
        check("mtlo_no_busy", 64'(busy_of(w)), 64'd0);
        @(posedge CLK); #1;
        set_start(w, 1'b0);
        check("mt_hi", 64'(hi_of(w)), 64'h1234);
        check("mt_lo", 64'(lo_of(w)), 64'h5678);
        check("mt_no_done", 64'(done_of(w)), 64'd0);

        op_r = 3'd1; rs_r = 32'd9; rt_r = 32'd9;
        set_start(w, 1'b1);
        set_cancel(w, 1'b1);
        @(posedge CLK); #1;
        set_start(w, 1'b0);
        set_cancel(w, 1'b0);
        check("start_with_cancel_dropped", 64'(busy_of(w)), 64'd0);

        issue(w, 3'd3, 32'd100, 32'd7, 10, 1'b0);
        issue(w, 3'd3, 32'd100, 32'd7, 0, 1'b0);

        op_r = 3'd1; rs_r = 32'hFFFF; rt_r = 32'h1234;
        set_start(w, 1'b1);
        @(posedge CLK); #1;
        set_start(w, 1'b0);
        repeat (4) begin
            @(posedge CLK); #1;
        end
        check("pre_reset_busy", 64'(busy_of(w)), 64'd1);
        RST = 1'b1;
        #1;
        check("rst_busy", 64'(busy_of(w)), 64'd0);
        check("rst_hi", 64'(hi_of(w)), 64'd0);
        check("rst_lo", 64'(lo_of(w)), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        issue(w, 3'd1, 32'd3, 32'd4, 0, 1'b0);
    endtask

    initial begin
        RST = 1'b1;
        start_a = 1'b0; start_b = 1'b0; cancel_a = 1'b0; cancel_b = 1'b0;
        op_r = 3'd7; rs_r = '0; rt_r = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy_a", 64'(busy_a), 64'd0);
        check("reset_done_a", 64'(done_a), 64'd0);
        check("reset_dbz_a",  64'(dbz_a),  64'd0);
        check("reset_hilo_a", {hi_a, lo_a}, 64'd0);
        check("reset_busy_b", 64'(busy_b), 64'd0);
        check("reset_hilo_b", {32'h0, hi_b, lo_b}, 64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        run_suite(32);
        run_suite(16);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
